// File: rtl/out_buf_fifo_if.sv
// Allocator write stream and output-link handshake of one router output buffer.
// The slave modport is the buffer; the master modport is whatever drives it.
interface out_buf_fifo_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic          FifoWr_i;
  logic [31:0]   FifoWrData_i;
  logic          FifoFull_o;
  logic          OutValid_o;
  logic [31:0]   OutData_o;
  logic          OutReady_i;
  logic [AW:0]   Count_o;
  logic [AW:0]   PktCount_o;
  logic          WrErr_o;

  modport slave (
    input  FifoWr_i, FifoWrData_i, OutReady_i,
    output FifoFull_o, OutValid_o, OutData_o, Count_o, PktCount_o, WrErr_o
  );

  modport master (
    output FifoWr_i, FifoWrData_i, OutReady_i,
    input  FifoFull_o, OutValid_o, OutData_o, Count_o, PktCount_o, WrErr_o
  );
endinterface

// File: rtl/out_buf_fifo.sv
// First-word-fall-through flit buffer for one router output port, with
// occupancy, stored-tail count and a sticky overflow flag.
module out_buf_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic           clk,
  input  logic           rstn,
  out_buf_fifo_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [1:0]    TYPE_TAIL = 2'b11;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic          wr_err_q, wr_err_d;

  logic          full, empty, wr_ok, rd_ok, wr_tail, rd_tail;

  // Full/valid come from registered count only; no path from OutReady_i.
  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign wr_ok   = bus.FifoWr_i && !full;
  assign rd_ok   = bus.OutReady_i && !empty;
  assign wr_tail = (bus.FifoWrData_i[31:30] == TYPE_TAIL);
  assign rd_tail = (mem_q[rd_ptr_q][31:30] == TYPE_TAIL);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    pkt_cnt_d = pkt_cnt_q;
    wr_err_d  = wr_err_q;

    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    if (bus.FifoWr_i && full) wr_err_d = 1'b1;

    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    unique case ({wr_ok && wr_tail, rd_ok && rd_tail})
      2'b10:   pkt_cnt_d = pkt_cnt_q + CW'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - CW'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pkt_cnt_q <= '0;
      wr_err_q  <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pkt_cnt_q <= pkt_cnt_d;
      wr_err_q  <= wr_err_d;
    end
  end

  // Storage is deliberately not reset; stale entries are masked by count.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= bus.FifoWrData_i;
  end

  assign bus.FifoFull_o = full;
  assign bus.OutValid_o = !empty;
  assign bus.OutData_o  = empty ? 32'h0 : mem_q[rd_ptr_q];
  assign bus.Count_o    = count_q;
  assign bus.PktCount_o = pkt_cnt_q;
  assign bus.WrErr_o    = wr_err_q;
endmodule

// File: tb/tb_out_buf_fifo.sv
// Directed bench for out_buf_fifo: hand-picked flit sequences checked against
// constants and a small queue reference.
module tb_out_buf_fifo;
  localparam int unsigned DEPTH = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  out_buf_fifo_if #(.DEPTH(DEPTH)) bif ();
  out_buf_fifo #(.DEPTH(DEPTH)) dut (.clk(clk), .rstn(rstn), .bus(bif));

  int n_chk = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int tails();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i][31:30] == 2'b11) n++;
    return n;
  endfunction

  // Compare all observable state against the reference queue.
  task automatic chk_model(input string tag);
    int s = exp_q.size();
    chk({tag, ".valid"}, 32'(bif.OutValid_o), 32'(s != 0));
    chk({tag, ".data"},  bif.OutData_o, (s != 0) ? exp_q[0] : 32'h0);
    chk({tag, ".cnt"},   32'(bif.Count_o), 32'(s));
    chk({tag, ".pkt"},   32'(bif.PktCount_o), 32'(tails()));
    chk({tag, ".full"},  32'(bif.FifoFull_o), 32'(s == int'(DEPTH)));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock with the given strobes; model follows the pre-edge occupancy.
  task automatic cyc(input logic wr, input logic [31:0] d, input logic rd);
    int s = exp_q.size();
    bif.FifoWr_i     = wr;
    bif.FifoWrData_i = d;
    bif.OutReady_i   = rd;
    step();
    bif.FifoWr_i   = 1'b0;
    bif.OutReady_i = 1'b0;
    if (rd && s > 0) void'(exp_q.pop_front());
    if (wr && s < int'(DEPTH)) exp_q.push_back(d);
  endtask

  initial begin
    logic [31:0] flits [8];
    logic [31:0] d;
    flits[0] = 32'h0000_0001;
    for (int i = 1; i < 7; i++) flits[i] = 32'h4000_0000 + 32'(i + 1);
    flits[7] = 32'hC000_0008;

    bif.FifoWr_i     = 1'b0;
    bif.FifoWrData_i = 32'h0;
    bif.OutReady_i   = 1'b0;

    // Reset and idle
    #12;
    chk("rst.cnt",   32'(bif.Count_o), 32'd0);
    chk("rst.valid", 32'(bif.OutValid_o), 32'd0);
    chk("rst.data",  bif.OutData_o, 32'h0);
    chk("rst.full",  32'(bif.FifoFull_o), 32'd0);
    chk("rst.err",   32'(bif.WrErr_o), 32'd0);
    chk("rst.pkt",   32'(bif.PktCount_o), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    step();
    chk("idle.cnt",  32'(bif.Count_o), 32'd0);

    // Single head flit, one-cycle latency, then drain
    cyc(1'b1, 32'h0000_0001, 1'b0);
    chk("one.valid", 32'(bif.OutValid_o), 32'd1);
    chk("one.data",  bif.OutData_o, 32'h0000_0001);
    chk("one.cnt",   32'(bif.Count_o), 32'd1);
    chk("one.pkt",   32'(bif.PktCount_o), 32'd0);
    cyc(1'b0, 32'h0, 1'b1);
    chk("one.rd.valid", 32'(bif.OutValid_o), 32'd0);
    chk("one.rd.data",  bif.OutData_o, 32'h0);

    // Fill with one full packet
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("fill7.full", 32'(bif.FifoFull_o), 32'd0);
      cyc(1'b1, flits[i], 1'b0);
    end
    chk("fill.full", 32'(bif.FifoFull_o), 32'd1);
    chk("fill.cnt",  32'(bif.Count_o), 32'd8);
    chk("fill.pkt",  32'(bif.PktCount_o), 32'd1);
    chk("fill.head", bif.OutData_o, 32'h0000_0001);

    // Write while full is dropped and flagged
    cyc(1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("ovf.err",  32'(bif.WrErr_o), 32'd1);
    chk("ovf.cnt",  32'(bif.Count_o), 32'd8);
    chk("ovf.data", bif.OutData_o, 32'h0000_0001);

    // Drain back-to-back in order
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d.data", i), bif.OutData_o, flits[i]);
      chk($sformatf("drain%0d.pkt", i), 32'(bif.PktCount_o), 32'd1);
      cyc(1'b0, 32'h0, 1'b1);
      if (i == 0) chk("drain.full", 32'(bif.FifoFull_o), 32'd0);
    end
    chk("drain.pkt",   32'(bif.PktCount_o), 32'd0);
    chk("drain.valid", 32'(bif.OutValid_o), 32'd0);
    chk("drain.err",   32'(bif.WrErr_o), 32'd1);
    chk_model("drain");

    // Full read with same-cycle write: read frees space one cycle later
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'h5000_0000 + 32'(i), 1'b0);
    cyc(1'b1, 32'h7777_7777, 1'b1);
    chk_model("fullrw");
    for (int i = 0; i < 7; i++) cyc(1'b0, 32'h0, 1'b1);
    chk_model("fullrw.empty");

    // Steady state at three entries with concurrent traffic; pointers wrap
    for (int k = 0; k < 3; k++) cyc(1'b1, {2'b01, 30'(k)}, 1'b0);
    chk_model("c3");
    for (int k = 3; k < 23; k++) begin
      d = {(k % 4 == 3) ? 2'b11 : 2'b01, 30'(k)};
      cyc(1'b1, d, 1'b1);
      chk(  $sformatf("conc%0d.cnt", k), 32'(bif.Count_o), 32'd3);
      chk_model($sformatf("conc%0d", k));
    end
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 32'h0, 1'b1);
      chk_model($sformatf("ctail%0d", k));
    end

    // Asynchronous reset with five entries held
    for (int k = 0; k < 5; k++) cyc(1'b1, (k == 4) ? 32'hC000_0055 : 32'h4000_0050 + 32'(k), 1'b0);
    chk_model("pre_rst");
    #2;
    rstn = 1'b0;
    #1;
    exp_q.delete();
    chk("arst.cnt",   32'(bif.Count_o), 32'd0);
    chk("arst.valid", 32'(bif.OutValid_o), 32'd0);
    chk("arst.data",  bif.OutData_o, 32'h0);
    chk("arst.pkt",   32'(bif.PktCount_o), 32'd0);
    chk("arst.full",  32'(bif.FifoFull_o), 32'd0);
    chk("arst.err",   32'(bif.WrErr_o), 32'd0);
    #2;
    rstn = 1'b1;
    step();
    cyc(1'b1, 32'hC000_0ABC, 1'b0);
    chk("post.data", bif.OutData_o, 32'hC000_0ABC);
    chk("post.cnt",  32'(bif.Count_o), 32'd1);
    chk("post.pkt",  32'(bif.PktCount_o), 32'd1);
    cyc(1'b0, 32'h0, 1'b1);
    chk_model("post.rd");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
